// File: rtl/merger_pkg.sv
// Shared merger-tree types and helpers: run terminator FSM states and the
// all-ones terminator beat generator.
package merger_pkg;

  localparam int unsigned LP_NUM_READ_CHANNELS = 8;
  localparam int unsigned LP_MAX_DATA_WIDTH    = 2048;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    TERM,
    DRAIN,
    FINISH
  } run_term_state_t;

  // All ones in the low `width` bits: every key at its maximum value.
  function automatic logic [LP_MAX_DATA_WIDTH-1:0] term_beat(input int unsigned width);
    logic [LP_MAX_DATA_WIDTH-1:0] beat;
    beat = '0;
    for (int unsigned i = 0; i < LP_MAX_DATA_WIDTH; i++) begin
      if (i < width) beat[i] = 1'b1;
    end
    return beat;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-stream output register: loads whenever the slot is empty or
// being drained this cycle, otherwise holds data and last stable.
module axis_out_reg #(
  parameter int unsigned C_DATA_WIDTH = 512
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    load,
  input  logic [C_DATA_WIDTH-1:0] load_data,
  input  logic                    load_last,
  input  logic                    ready,
  output logic                    valid,
  output logic [C_DATA_WIDTH-1:0] data,
  output logic                    last,
  output logic                    out_free_c
);

  assign out_free_c = !valid || ready;

  // Callers only raise load while out_free_c is high.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/run_terminator.sv
// Chops a read stream into runs of a programmed length and appends an all-ones
// terminator beat after each run. Optional tlast check: RUN_TERM_TLAST_CHECK_EN.
module run_terminator
  import merger_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH       = 512,
  parameter int unsigned C_SORTER_BIT_WIDTH = 32,
  parameter int unsigned C_LEN_WIDTH        = 32
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    ctrl_start,
  input  logic [C_LEN_WIDTH-1:0]  ctrl_run_len_beats,
  input  logic [C_LEN_WIDTH-1:0]  ctrl_num_runs,
  output logic                    ctrl_done,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    err_tlast_mismatch
);

  localparam int unsigned LP_NUM_KEYS = C_DATA_WIDTH / C_SORTER_BIT_WIDTH;
  localparam logic [C_SORTER_BIT_WIDTH-1:0] LP_KEY_MAX =
    C_SORTER_BIT_WIDTH'(term_beat(C_SORTER_BIT_WIDTH));
  localparam logic [C_DATA_WIDTH-1:0] LP_TERM_BEAT = {LP_NUM_KEYS{LP_KEY_MAX}};

  run_term_state_t        state;
  logic [C_LEN_WIDTH-1:0] len_q;
  logic [C_LEN_WIDTH-1:0] runs_q;
  logic [C_LEN_WIDTH-1:0] beat_cnt;
  logic [C_LEN_WIDTH-1:0] run_cnt;

  logic                    out_free;
  logic                    s_hs;
  logic                    last_data_beat;
  logic                    last_run;
  logic                    load;
  logic [C_DATA_WIDTH-1:0] load_data;
  logic                    load_last;

  assign s_axis_tready  = (state == DATA) && out_free;
  assign s_hs           = s_axis_tvalid && s_axis_tready;
  assign last_data_beat = (beat_cnt == C_LEN_WIDTH'(len_q - C_LEN_WIDTH'(1)));
  assign last_run       = (C_LEN_WIDTH'(run_cnt + C_LEN_WIDTH'(1)) == runs_q);

  // Terminator takes the output slot only in TERM; otherwise upstream data.
  always_comb begin
    load      = s_hs;
    load_data = s_axis_tdata;
    load_last = 1'b0;
    if (state == TERM) begin
      load      = out_free;
      load_data = LP_TERM_BEAT;
      load_last = 1'b1;
    end
  end

  axis_out_reg #(
    .C_DATA_WIDTH(C_DATA_WIDTH)
  ) u_out_reg (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .load       (load),
    .load_data  (load_data),
    .load_last  (load_last),
    .ready      (m_axis_tready),
    .valid      (m_axis_tvalid),
    .data       (m_axis_tdata),
    .last       (m_axis_tlast),
    .out_free_c (out_free)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      len_q     <= '0;
      runs_q    <= '0;
      beat_cnt  <= '0;
      run_cnt   <= '0;
      ctrl_done <= 1'b0;
    end else begin
      ctrl_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_start) begin
            len_q    <= ctrl_run_len_beats;
            runs_q   <= ctrl_num_runs;
            beat_cnt <= '0;
            run_cnt  <= '0;
            if (ctrl_num_runs == '0)           state <= FINISH;
            else if (ctrl_run_len_beats == '0) state <= TERM;
            else                               state <= DATA;
          end
        end
        DATA: begin
          if (s_hs) begin
            beat_cnt <= C_LEN_WIDTH'(beat_cnt + C_LEN_WIDTH'(1));
            if (last_data_beat) state <= TERM;
          end
        end
        TERM: begin
          // Stay here under backpressure until the terminator is loaded.
          if (out_free) begin
            run_cnt  <= C_LEN_WIDTH'(run_cnt + C_LEN_WIDTH'(1));
            beat_cnt <= '0;
            if (last_run)          state <= DRAIN;
            else if (len_q == '0)  state <= TERM;
            else                   state <= DATA;
          end
        end
        DRAIN: begin
          if (out_free) state <= FINISH;
        end
        FINISH: begin
          ctrl_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RUN_TERM_TLAST_CHECK_EN
  logic err_q;

  // Sticky: upstream tlast must mark exactly the last data beat of each run.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      err_q <= 1'b0;
    end else if ((state == IDLE) && ctrl_start) begin
      err_q <= 1'b0;
    end else if (s_hs && (s_axis_tlast != last_data_beat)) begin
      err_q <= 1'b1;
    end
  end

  assign err_tlast_mismatch = err_q;
`else
  logic unused_tlast;
  assign unused_tlast       = s_axis_tlast;
  assign err_tlast_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_run_terminator.sv
// Randomized scoreboard bench for run_terminator: a run/terminator model fills
// the expected queue; a negedge monitor checks every accepted output beat.
module tb_run_terminator;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = 32;
  localparam int unsigned LW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ctrl_start = 1'b0;
  logic [LW-1:0] ctrl_len = '0;
  logic [LW-1:0] ctrl_runs = '0;
  logic          ctrl_done;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_tlast = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          err;

  run_terminator #(
    .C_DATA_WIDTH      (DW),
    .C_SORTER_BIT_WIDTH(KW),
    .C_LEN_WIDTH       (LW)
  ) dut (
    .aclk              (clk),
    .areset_n          (rst_n),
    .ctrl_start        (ctrl_start),
    .ctrl_run_len_beats(ctrl_len),
    .ctrl_num_runs     (ctrl_runs),
    .ctrl_done         (ctrl_done),
    .s_axis_tvalid     (s_valid),
    .s_axis_tready     (s_ready),
    .s_axis_tdata      (s_data),
    .s_axis_tlast      (s_tlast),
    .m_axis_tvalid     (m_valid),
    .m_axis_tready     (m_ready),
    .m_axis_tdata      (m_data),
    .m_axis_tlast      (m_last),
    .err_tlast_mismatch(err)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  beat_t exp_q[$];

  int            done_cnt = 0;
  int            done_cyc = 0;
  int            first_acc = -1;
  int            last_acc = -1;
  int            out_beats = 0;
  int            s_ready_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < int'(DW / 32); k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Monitor: scoreboard pops, stall stability, done and ready bookkeeping.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_int("stall_valid", int'(m_valid), 1);
        check_vec("stall_data", m_data, prev_data);
        check_int("stall_last", int'(m_last), int'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat actual=%h required=none", m_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check_vec("beat_data", m_data, e.data);
          check_int("beat_last", int'(m_last), int'(e.last));
        end
        out_beats++;
        if (first_acc < 0) first_acc = cyc + 1;
        last_acc = cyc + 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (s_ready) s_ready_cnt++;
      if (ctrl_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference model: each run is len data words followed by one all-ones beat.
  task automatic build_pass(input int len, input int runs, output logic [DW-1:0] words[$]);
    beat_t b;
    words.delete();
    for (int r = 0; r < runs; r++) begin
      for (int i = 0; i < len; i++) begin
        words.push_back(rand_word());
        b.data = words[words.size() - 1];
        b.last = 1'b0;
        exp_q.push_back(b);
      end
      b.data = {DW{1'b1}};
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic run_pass(input int len, input int runs, input int rmode, input bit gaps,
                          input bit mid_start, input int err_idx, output int start_c);
    logic [DW-1:0] words[$];
    int idx = 0;
    int d0;
    bit finished = 1'b0;
    build_pass(len, runs, words);
    first_acc   = -1;
    last_acc    = -1;
    out_beats   = 0;
    d0          = done_cnt;
    @(posedge clk); #1;
    ctrl_start  = 1'b1;
    ctrl_len    = LW'(len);
    ctrl_runs   = LW'(runs);
    start_c     = cyc;
    s_ready_cnt = 0;
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) begin
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (n % 2) == 0;
        default: m_ready = $urandom_range(0, 3) != 0;
      endcase
      ctrl_start = mid_start && (n == 3);
      if (mid_start && n == 3) begin
        ctrl_len  = LW'(9);
        ctrl_runs = LW'(7);
      end
      if (idx < words.size()) begin
        s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_data  = words[idx];
        s_tlast = ((idx % len) == len - 1) ^ (idx == err_idx);
      end else begin
        s_valid = 1'b0;
        s_tlast = 1'b0;
      end
      @(negedge clk); #1;
      if (s_valid && s_ready) idx++;
      if (done_cnt != d0) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid    = 1'b0;
    ctrl_start = 1'b0;
    m_ready    = 1'b1;
    check_int("done_seen", int'(finished), 1);
    check_int("queue_drained", exp_q.size(), 0);
    check_int("inputs_consumed", idx, words.size());
    if (runs > 0) check_int("done_latency", done_cyc, last_acc + 1);
    @(posedge clk); @(negedge clk);
    check_int("done_width", int'(ctrl_done), 0);
    check_int("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int sc;
    logic [DW-1:0] words[$];
    int idx;

    #1;
    check_int("rst_m_valid", int'(m_valid), 0);
    check_vec("rst_m_data", m_data, '0);
    check_int("rst_m_last", int'(m_last), 0);
    check_int("rst_done", int'(ctrl_done), 0);
    check_int("rst_s_ready", int'(s_ready), 0);
    check_int("rst_err", int'(err), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // len=4 runs=2, full throughput: 10 consecutive output beats, 2 input bubbles.
    run_pass(4, 2, 0, 1'b0, 1'b0, -1, sc);
    check_int("tp_beats", out_beats, 10);
    check_int("tp_first_out", first_acc, sc + 3);
    check_int("tp_span", last_acc - first_acc, 9);
    check_int("tp_s_ready_cycles", s_ready_cnt, 8);

    // Toggling downstream ready: stalled beats held stable.
    run_pass(3, 1, 1, 1'b0, 1'b0, -1, sc);
    check_int("toggle_beats", out_beats, 4);

    // Zero-length runs: terminators only, upstream never ready.
    run_pass(0, 3, 0, 1'b0, 1'b0, -1, sc);
    check_int("len0_beats", out_beats, 3);
    check_int("len0_s_ready", s_ready_cnt, 0);

    // Zero runs: done two cycles after start, no output.
    run_pass(5, 0, 0, 1'b0, 1'b0, -1, sc);
    check_int("runs0_beats", out_beats, 0);
    check_int("runs0_done_latency", done_cyc - sc, 2);

    // Second start mid-pass is ignored.
    run_pass(4, 2, 0, 1'b0, 1'b1, -1, sc);
    check_int("midstart_beats", out_beats, 10);

    // Reset in DATA after two accepted beats.
    build_pass(4, 1, words);
    @(posedge clk); #1;
    ctrl_start = 1'b1;
    ctrl_len   = LW'(4);
    ctrl_runs  = LW'(1);
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    idx = 0;
    for (int n = 0; n < 50 && idx < 2; n++) begin
      s_valid = 1'b1;
      s_data  = words[idx];
      s_tlast = 1'b0;
      @(negedge clk); #1;
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1;
    end
    check_int("rst_mid_fed", idx, 2);
    #1 rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    check_int("rstmid_m_valid", int'(m_valid), 0);
    check_vec("rstmid_m_data", m_data, '0);
    check_int("rstmid_m_last", int'(m_last), 0);
    check_int("rstmid_s_ready", int'(s_ready), 0);
    check_int("rstmid_done", int'(ctrl_done), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_pass(2, 1, 0, 1'b0, 1'b0, -1, sc);
    check_int("post_rst_beats", out_beats, 3);

`ifdef RUN_TERM_TLAST_CHECK_EN
    // Upstream tlast on beat 3 of a len=4 run: sticky error, stream unchanged.
    run_pass(4, 1, 0, 1'b0, 1'b0, 2, sc);
    check_int("err_set", int'(err), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("err_sticky", int'(err), 1);
    run_pass(2, 1, 0, 1'b0, 1'b0, -1, sc);
    check_int("err_cleared", int'(err), 0);
`endif

    // Randomized passes with input gaps and random backpressure.
    for (int p = 0; p < 8; p++) begin
      run_pass($urandom_range(0, 6), $urandom_range(1, 3), 2, 1'b1, 1'b0, -1, sc);
    end

    check_int("err_final", int'(err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_terminator.md
Name: run_terminator

Overview:
- Per-channel stream stage between one axi_read_master output channel and one MERGER_INTEGRATION input port; eight instances per tree.
- Chops the read stream into sorted runs of a programmed length.
- After each run, inserts one terminator beat with every key at maximum value, so the merger drains each run deterministically.
- Counts runs per pass and pulses done when the pass's input is exhausted.

Parameters:
- C_DATA_WIDTH, 512, stream beat width in bits (multiple of C_SORTER_BIT_WIDTH).
- C_SORTER_BIT_WIDTH, 32, key width; terminator beat = all ones, i.e. C_DATA_WIDTH/C_SORTER_BIT_WIDTH keys of max value.
- C_LEN_WIDTH, 32, width of run-length and run-count fields.

Ports:
- aclk  in  1  single clock.
- areset_n  in  1  asynchronous, active-low reset.
- ctrl_start  in  1  one-cycle pulse; latches ctrl_run_len_beats and ctrl_num_runs; ignored unless in IDLE.
- ctrl_run_len_beats  in  C_LEN_WIDTH  data beats per run in this pass.
- ctrl_num_runs  in  C_LEN_WIDTH  runs this channel delivers in this pass.
- ctrl_done  out  1  one-cycle pulse after the last terminator beat is accepted downstream.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- s_axis_tdata  in  C_DATA_WIDTH  upstream data.
- s_axis_tlast  in  1  upstream last (used only with the optional feature).
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  C_DATA_WIDTH  data or terminator beat.
- m_axis_tlast  out  1  high on each terminator beat.
- err_tlast_mismatch  out  1  sticky error flag (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - Counters = 0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - ctrl_done=0, s_axis_tready=0, err_tlast_mismatch=0.
- Output is a single pipeline register:
  - Loads when !m_axis_tvalid || m_axis_tready ("out_free").
  - Holds data and tlast stable while tvalid && !tready.
- FSM:
  - IDLE: on ctrl_start, latch len and runs, clear beat_cnt and run_cnt.
    - runs==0 -> FINISH.
    - len==0 -> TERM.
    - else -> DATA.
  - DATA:
    - s_axis_tready = out_free (combinational).
    - On s handshake: load register with s_axis_tdata, tlast=0, beat_cnt++.
    - When beat_cnt reaches len-1 on a handshake -> TERM.
  - TERM:
    - s_axis_tready=0.
    - When out_free: load all-ones, tlast=1, run_cnt++, beat_cnt=0.
    - If run_cnt+1==runs -> DRAIN; else -> DATA, or TERM again if len==0.
  - DRAIN: wait until the register is empty, or until it is accepted this cycle (m_axis_tvalid && m_axis_tready) -> FINISH.
  - FINISH: ctrl_done=1 for exactly one cycle -> IDLE.
- Throughput and latency:
  - One beat per cycle in DATA with downstream ready.
  - Terminator costs exactly one bubble cycle on the input side per run.
  - Input-to-output latency is 1 cycle.
- Counter comparisons use full C_LEN_WIDTH unsigned arithmetic; no wrap (len, runs <= 2^C_LEN_WIDTH-1).
- ctrl_start while not IDLE is ignored; no re-latch.
- Reset mid-pass: state and registers return immediately to reset values; any in-flight beat is discarded.
- Backpressure on the terminator: the register holds the terminator; the FSM does not advance past TERM until it is loaded.

Optional Feature:
- RUN_TERM_TLAST_CHECK_EN
- Defined:
  - Compares s_axis_tlast with the "last data beat of run" condition on every s handshake.
  - Any mismatch sets err_tlast_mismatch, sticky until reset or the next ctrl_start.
  - Data flow is unaffected.
- Undefined: err_tlast_mismatch tied to 0 and s_axis_tlast ignored; no logic is generated.

Decomposition:
- Package merger_pkg:
  - Typedef run_term_state_t {IDLE, DATA, TERM, DRAIN, FINISH}.
  - Function term_beat(width) returning all ones.
  - Constant LP_NUM_READ_CHANNELS=8, shared with the top level.
- One sub-module, axis_out_reg:
  - Valid/data/last register with the out_free load rule.
  - Reused by the write side.

Test Plan:
- len=4, runs=2, m ready always, s data 1..8 -> m beats 1,2,3,4,T,5,6,7,8,T; tlast only on T; ctrl_done one cycle after the second T accepted; 10 output beats in 10 cycles after the first input, plus 2 input bubbles.
- len=3, runs=1, m_axis_tready toggled 1/0 each cycle -> data and tlast held stable while stalled; output sequence d0,d1,d2,T unchanged; no beat lost or duplicated.
- len=0, runs=3 -> three consecutive T beats, s_axis_tready never asserted, ctrl_done after the third; runs=0 -> ctrl_done 2 cycles after ctrl_start, no m beats.
- areset_n asserted in DATA after 2 of 4 beats -> all outputs 0 asynchronously; new ctrl_start with len=2, runs=1 produces d,d,T cleanly.
- ctrl_start pulsed again mid-pass with len=9 -> ignored; original len=4 sequence completes.
- With RUN_TERM_TLAST_CHECK_EN, len=4, upstream tlast on beat 3 -> err_tlast_mismatch=1 from the next cycle and held; stream unchanged; cleared by the next ctrl_start.
